uart_rx: RTL and testbench

- 16x-oversampled UART receiver: 8N1 frames, LSB first, idle-high line.
- Direct downstream counterpart of the UART transmitter. Shares the same `baud_rate_tick` generator and consumes a serial line of the form the transmitter drives on `o_tx_data`.
- Delivers a parallel byte with a one-cycle `rx_done` strobe to the command/clock-control logic.
- Flags framing errors.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry, and the sample-vote helper.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous level input, resetting to 1 (idle-high lines, released buttons).
// Latency 2 clk; no flow control.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver; rx_done/frame_err strobe 1 clk after the mid-stop tick (+2 clk sync), no backpressure.
// Define UART_RX_MAJORITY_EN to take each bit decision as a 3-sample majority around the bit centre.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_rate_tick,
    input  logic                 i_rx_data,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic rx_s;
    logic bit_val;

    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;
    logic                 busy_q, busy_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (i_rx_data),
        .q_o   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // The two previous tick samples plus the live one form the 3-sample window; the
    // decision tick therefore votes over ticks N-2, N-1 and N.
    logic [1:0] smp_q;
    logic [2:0] smp_win;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            smp_q <= 2'b11;
        end else if (baud_rate_tick) begin
            smp_q <= {smp_q[0], rx_s};
        end
    end

    assign smp_win = {smp_q, rx_s};
    assign bit_val = maj3(smp_win[2], smp_win[1], smp_win[0]);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (baud_rate_tick) begin
                    if (tick_q == HALF_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = bit_val ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (baud_rate_tick) begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            STOP: begin
                if (baud_rate_tick) begin
                    if (tick_q == FULL_LAST) begin
                        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                        tick_d  = '0;
                        state_d = IDLE;
                        if (bit_val) begin
                            data_d = shift_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_rx_data = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of whole frames plus hand-written glitch, back-to-back, reset and majority sequences.
module tb_uart_rx;

    localparam int OS   = 16;
    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud_rate_tick;
    logic       i_rx_data;
    logic [7:0] o_rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    int tests = 0;
    int fails = 0;

    int         done_cnt  = 0;
    int         ferr_cnt  = 0;
    int         both_cnt  = 0;
    int         busy_clks = 0;
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        int         stop_n;
        logic [7:0] exp_data;
        int         exp_done;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    uart_rx dut (
        .clk            (clk),
        .reset          (reset),
        .baud_rate_tick (baud_rate_tick),
        .i_rx_data      (i_rx_data),
        .o_rx_data      (o_rx_data),
        .rx_done        (rx_done),
        .rx_busy        (rx_busy),
        .frame_err      (frame_err)
    );

    initial begin
        baud_rate_tick = 1'b0;
        forever begin
            repeat (TDIV - 1) @(negedge clk);
            baud_rate_tick = 1'b1;
            @(negedge clk);
            baud_rate_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            got_q.push_back(o_rx_data);
        end
        if (frame_err) ferr_cnt++;
        if (rx_done && frame_err) both_cnt++;
        if (rx_busy) busy_clks++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (baud_rate_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        @(negedge clk);
        i_rx_data = v;
        wait_ticks(n);
    endtask

    // glitch inverts the line for the single tick period ending at each data bit's centre tick
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_n, input logic glitch);
        send_bit(1'b0, OS);
        for (int i = 0; i < 8; i++) begin
            if (glitch) begin
                send_bit(d[i], OS / 2 - 1);
                send_bit(~d[i], 1);
                send_bit(d[i], OS / 2);
            end else begin
                send_bit(d[i], OS);
            end
        end
        send_bit(stop_v, stop_n);
        if (stop_n < OS) send_bit(1'b1, OS - stop_n);
    endtask

    initial begin
        int d0;
        int f0;
        int b0;
        logic [7:0] exp_maj;

        vecs[0] = '{data: 8'h55, stop_v: 1'b1, stop_n: 16, exp_data: 8'h55, exp_done: 1, exp_ferr: 0};
        vecs[1] = '{data: 8'hA3, stop_v: 1'b1, stop_n: 16, exp_data: 8'hA3, exp_done: 1, exp_ferr: 0};
        vecs[2] = '{data: 8'h00, stop_v: 1'b1, stop_n: 16, exp_data: 8'h00, exp_done: 1, exp_ferr: 0};
        vecs[3] = '{data: 8'hFF, stop_v: 1'b1, stop_n: 16, exp_data: 8'hFF, exp_done: 1, exp_ferr: 0};
        vecs[4] = '{data: 8'h3C, stop_v: 1'b0, stop_n: 10, exp_data: 8'hFF, exp_done: 0, exp_ferr: 1};

        reset     = 1'b1;
        i_rx_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", o_rx_data, 8'h00);
        check("reset_done", rx_done, 1'b0);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_busy", rx_busy, 1'b0);
        reset = 1'b0;
        send_bit(1'b1, 2 * OS);
        check("idle_busy", rx_busy, 1'b0);

        foreach (vecs[k]) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[k].data, vecs[k].stop_v, vecs[k].stop_n, 1'b0);
            send_bit(1'b1, 2 * OS);
            check($sformatf("vec%0d_data", k), o_rx_data, vecs[k].exp_data);
            check($sformatf("vec%0d_done", k), done_cnt - d0, vecs[k].exp_done);
            check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vecs[k].exp_ferr);
        end

        // Short low glitch on an idle line
        d0 = done_cnt;
        f0 = ferr_cnt;
        b0 = busy_clks;
        send_bit(1'b0, 5);
        send_bit(1'b1, 2 * OS);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_busy_seen", (busy_clks - b0) > 0, 1);
        check("glitch_busy_len", (busy_clks - b0) <= (OS / 2) * TDIV, 1);

        // Back-to-back frames with no idle between them
        got_q.delete();
        d0 = done_cnt;
        send_frame(8'h12, 1'b1, OS, 1'b0);
        send_frame(8'h34, 1'b1, OS, 1'b0);
        send_bit(1'b1, 2 * OS);
        check("b2b_count", done_cnt - d0, 2);
        check("b2b_first", (got_q.size() > 0) ? got_q[0] : 8'hxx, 8'h12);
        check("b2b_second", (got_q.size() > 1) ? got_q[1] : 8'hxx, 8'h34);
        check("b2b_data", o_rx_data, 8'h34);

        // Reset in the middle of bit 4 of 0xC7
        send_bit(1'b0, OS);
        for (int i = 0; i < 4; i++) send_bit(((8'hC7 >> i) & 8'h01) != 0, OS);
        send_bit(1'b0, OS / 2);
        check("midframe_busy", rx_busy, 1'b1);
        @(negedge clk);
        reset     = 1'b1;
        i_rx_data = 1'b1;
        #1;
        check("rst_mid_data", o_rx_data, 8'h00);
        check("rst_mid_done", rx_done, 1'b0);
        check("rst_mid_ferr", frame_err, 1'b0);
        check("rst_mid_busy", rx_busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_bit(1'b1, 2 * OS);
        send_frame(8'h81, 1'b1, OS, 1'b0);
        send_bit(1'b1, 2 * OS);
        check("post_rst_data", o_rx_data, 8'h81);
        check("post_rst_done", done_cnt - d0, 1);
        check("post_rst_ferr", ferr_cnt - f0, 0);

        // One-tick inverted glitch at each data bit centre
`ifdef UART_RX_MAJORITY_EN
        exp_maj = 8'hAA;
`else
        exp_maj = 8'h55;
`endif
        d0 = done_cnt;
        send_frame(8'hAA, 1'b1, OS, 1'b1);
        send_bit(1'b1, 2 * OS);
        check("centre_glitch_data", o_rx_data, exp_maj);
        check("centre_glitch_done", done_cnt - d0, 1);

        check("done_ferr_overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
